dmem_responder: RTL and testbench
=================================

# dmem_responder

Responder end of the data-memory request interface driven by the pipeline's MEM stage. It accepts one request at a time (read, or byte-masked write), runs it on an external word-wide memory bus with a req/ack handshake, and returns a one-cycle `mem_done` pulse with read data. An optional one-entry posted-write buffer lets stores retire without waiting for the external bus.

## Interface
- Parameters: none.
- `CLK` in 1: clock; all state changes on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `rw_flag` in 2: request type. 0 = none, 1 = read, 2 = write, 3 = treated as none.
- `addr` in 32: byte address. Bits [1:0] are ignored; the request is word-granular.
- `write_data` in 32: store data, already lane-aligned.
- `write_mask` in 4: byte enables; bit i enables byte lane i (little endian).
- `read_data` out 32: read result. Valid only while `mem_done`=1 for a read; 0 otherwise.
- `mem_busy` out 1: responder cannot accept a request this cycle.
- `mem_done` out 1: one-cycle completion pulse for the oldest accepted request.
- `ext_req` out 1: external bus request. Held high until acknowledged.
- `ext_we` out 1: 1 = write, 0 = read. Valid while `ext_req`=1.
- `ext_addr` out 30: word address (byte address [31:2]).
- `ext_wdata` out 32: write data for the external bus.
- `ext_wmask` out 4: byte enables for the external bus.
- `ext_ack` in 1: bus completion; sampled on the rising edge while `ext_req`=1.
- `ext_rdata` in 32: read data, valid in the same cycle as `ext_ack`.

## Operation
- States: IDLE, BUS, DRAIN (DRAIN exists only with the macro), DONE.
- `mem_busy` = 1 in BUS and DRAIN, 0 in IDLE and DONE.
  - `mem_busy` is a pure function of registered state and never depends on `rw_flag`. The initiator gates `rw_flag` with `mem_busy`, so any dependency would form a combinational loop.
- Acceptance: in IDLE or DONE, `rw_flag` ∈ {1,2} at a rising edge accepts the request.
  - On acceptance, `addr[31:2]`, `write_data`, `write_mask` and the type are latched into the request registers.
- Base path (no macro): an accepted request goes IDLE/DONE → BUS.
  - In BUS, `ext_req`=1 and the `ext_*` outputs are driven from the request registers.
  - On an edge with `ext_ack`=1: latch `ext_rdata` (reads only) and go → DONE.
- DONE lasts exactly one cycle.
  - `mem_done`=1; `read_data` = latched data for a read, 0 for a write.
  - In the same edge, a new request may be accepted; otherwise go → IDLE.
- A write with `write_mask`=0 still performs the full bus transaction.
- Outside BUS and DRAIN, `ext_req`=0 and `ext_we`, `ext_addr`, `ext_wdata`, `ext_wmask` are 0.

## Timing
- Reset (RST high at an edge): state IDLE, buffer invalid, all request and data registers cleared.
  - Outputs after reset: `mem_busy`=0, `mem_done`=0, `read_data`=0, `ext_req`=0, all other `ext_*` outputs 0.
  - Reset during BUS or DRAIN abandons the transaction: `ext_req` drops the next cycle and no `mem_done` is generated.
- Latency, base path, acceptance edge = E0:
  - `ext_req` rises in the cycle after E0.
  - If `ext_ack` is first seen at edge E0+k, `mem_done` is high in the cycle after E0+k.
  - Minimum acceptance-to-`mem_done` latency is 2 cycles, with `ext_ack` tied high.
- Back-to-back: a request accepted in a DONE cycle costs no idle cycle between transactions.
- `ext_ack` is ignored while `ext_req`=0.
- `ext_*` outputs stay stable from `ext_req` rise until the acknowledging edge.
- Exactly one `mem_done` is produced per accepted request, in acceptance order.

## Configuration
- Macro `DMEM_WRITE_BUFFER_EN`. When defined, a one-entry posted-write buffer (`wb_valid`, addr, data, mask) is added.
- Accepted write with buffer empty: capture into the buffer, go → DONE (`mem_done` in the next cycle, no bus activity).
- Accepted write with buffer full: go → DRAIN.
  - DRAIN issues the old buffer entry on the bus (`ext_we`=1).
  - On `ext_ack`, move the request registers into the buffer and go → DONE.
- Accepted read with buffer full: DRAIN, then BUS read, then DONE. Reads are never forwarded from the buffer; order is preserved.
- In IDLE or DONE with the buffer full and no request: go → DRAIN. On `ext_ack`, invalidate the buffer and go → IDLE.
- Not defined: DRAIN and the buffer do not exist, and writes follow the base path.

## Test plan
- Read, `ext_ack` tied 1: `rw_flag`=1, `addr`=0x0000_1007, `ext_rdata`=0xDEAD_BEEF.
  - `ext_addr`=0x0000_0401 with `ext_we`=0 in the cycle after acceptance.
  - Next cycle: `mem_done`=1, `read_data`=0xDEAD_BEEF.
- Write with `ext_ack` delayed 3 cycles: `write_mask`=0b0110, `write_data`=0x00AB_CD00.
  - `mem_busy`=1 for 3 cycles, `ext_*` outputs held stable throughout.
  - One `mem_done`, with `read_data`=0.
- Back-to-back: a read accepted in the DONE cycle of a previous write.
  - `ext_req` is high in the very next cycle.
  - Two `mem_done` pulses, in order.
- Reset mid-BUS: `ext_req` falls the cycle after RST.
  - No `mem_done`; all outputs equal their reset values.
- `DMEM_WRITE_BUFFER_EN`: write to 0x40 (`mem_done` 1 cycle later, `ext_req`=0), then a read of 0x40.
  - The bus write of 0x40 is acknowledged before the bus read is issued.
  - The read returns `ext_rdata`.
- `DMEM_WRITE_BUFFER_EN`, idle with buffer full: the buffer drains autonomously with `mem_busy`=1.
  - Afterwards `mem_busy`=0 and `ext_req`=0.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Data-memory responder: one read or byte-masked write at a time,
//            carried out over a req/ack word bus and answered by a mem_done
//            pulse. Optional posted-write buffer: DMEM_WRITE_BUFFER_EN.
// Revision : 1.0
// ============================================================================
module dmem_responder (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  rw_flag,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_mask,
  output logic [31:0] read_data,
  output logic        mem_busy,
  output logic        mem_done,
  output logic        ext_req,
  output logic        ext_we,
  output logic [29:0] ext_addr,
  output logic [31:0] ext_wdata,
  output logic [3:0]  ext_wmask,
  input  logic        ext_ack,
  input  logic [31:0] ext_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUS   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] c_RW_READ  = 2'd1;
  localparam logic [1:0] c_RW_WRITE = 2'd2;

  state_t      r_state;
  logic [29:0] r_req_addr;
  logic [31:0] r_req_wdata;
  logic [3:0]  r_req_wmask;
  logic        r_req_we;
  logic [31:0] r_read_data;

  logic w_accept;
  logic w_is_write;
  logic w_bus;
  logic w_drain;
  logic w_unused_addr_lsb;

  assign w_accept          = (rw_flag == c_RW_READ) || (rw_flag == c_RW_WRITE);
  assign w_is_write        = (rw_flag == c_RW_WRITE);
  assign w_bus             = (r_state == S_BUS);
  assign w_unused_addr_lsb = ^addr[1:0];

`ifdef DMEM_WRITE_BUFFER_EN
  logic        r_wb_valid;
  logic [29:0] r_wb_addr;
  logic [31:0] r_wb_wdata;
  logic [3:0]  r_wb_wmask;
  logic        r_req_pend;   // a request is waiting behind the drain

  assign w_drain   = (r_state == S_DRAIN);
  assign ext_we    = w_drain | (w_bus & r_req_we);
  assign ext_addr  = w_drain ? r_wb_addr  : (w_bus ? r_req_addr  : 30'd0);
  assign ext_wdata = w_drain ? r_wb_wdata : (w_bus ? r_req_wdata : 32'd0);
  assign ext_wmask = w_drain ? r_wb_wmask : (w_bus ? r_req_wmask : 4'd0);
`else
  assign w_drain   = 1'b0;
  assign ext_we    = w_bus & r_req_we;
  assign ext_addr  = w_bus ? r_req_addr  : 30'd0;
  assign ext_wdata = w_bus ? r_req_wdata : 32'd0;
  assign ext_wmask = w_bus ? r_req_wmask : 4'd0;
`endif

  // Handshake outputs decode registered state only, never rw_flag.
  assign ext_req   = w_bus | w_drain;
  assign mem_busy  = w_bus | w_drain;
  assign mem_done  = (r_state == S_DONE);
  assign read_data = r_read_data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_req_addr  <= 30'd0;
      r_req_wdata <= 32'd0;
      r_req_wmask <= 4'd0;
      r_req_we    <= 1'b0;
      r_read_data <= 32'd0;
`ifdef DMEM_WRITE_BUFFER_EN
      r_wb_valid  <= 1'b0;
      r_wb_addr   <= 30'd0;
      r_wb_wdata  <= 32'd0;
      r_wb_wmask  <= 4'd0;
      r_req_pend  <= 1'b0;
`endif
    end else begin
      r_read_data <= 32'd0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_req_addr  <= addr[31:2];
            r_req_wdata <= write_data;
            r_req_wmask <= write_mask;
            r_req_we    <= w_is_write;
`ifdef DMEM_WRITE_BUFFER_EN
            r_req_pend  <= 1'b1;
            if (r_wb_valid) begin
              r_state <= S_DRAIN;
            end else if (w_is_write) begin
              r_wb_valid <= 1'b1;
              r_wb_addr  <= addr[31:2];
              r_wb_wdata <= write_data;
              r_wb_wmask <= write_mask;
              r_state    <= S_DONE;
            end else begin
              r_state <= S_BUS;
            end
`else
            r_state <= S_BUS;
`endif
          end else begin
`ifdef DMEM_WRITE_BUFFER_EN
            r_req_pend <= 1'b0;
            r_state    <= r_wb_valid ? S_DRAIN : S_IDLE;
`else
            r_state <= S_IDLE;
`endif
          end
        end
        S_BUS: begin
          if (ext_ack) begin
            r_state     <= S_DONE;
            r_read_data <= r_req_we ? 32'd0 : ext_rdata;
          end
        end
`ifdef DMEM_WRITE_BUFFER_EN
        S_DRAIN: begin
          if (ext_ack) begin
            if (!r_req_pend) begin
              r_wb_valid <= 1'b0;
              r_state    <= S_IDLE;
            end else if (r_req_we) begin
              // The new store takes the slot just freed; buffer stays valid.
              r_wb_addr  <= r_req_addr;
              r_wb_wdata <= r_req_wdata;
              r_wb_wmask <= r_req_wmask;
              r_state    <= S_DONE;
            end else begin
              r_state <= S_BUS;
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Self-checking bench for dmem_responder with a word memory bus
//            model and a program-order reference memory.
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  rw_flag = 2'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [3:0]  write_mask = 4'd0;
  logic [31:0] read_data;
  logic        mem_busy;
  logic        mem_done;
  logic        ext_req;
  logic        ext_we;
  logic [29:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [3:0]  ext_wmask;
  logic        ext_ack = 1'b0;
  logic [31:0] ext_rdata = 32'd0;

  dmem_responder dut (
    .CLK       (CLK),
    .RST       (RST),
    .rw_flag   (rw_flag),
    .addr      (addr),
    .write_data(write_data),
    .write_mask(write_mask),
    .read_data (read_data),
    .mem_busy  (mem_busy),
    .mem_done  (mem_done),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_wmask (ext_wmask),
    .ext_ack   (ext_ack),
    .ext_rdata (ext_rdata)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } bus_op_t;

  int          chk = 0;
  int          err = 0;
  int          ack_delay = 0;
  logic        ack_force = 1'b0;
  int          wcnt = 0;
  int          hs_count = 0;
  int          last_hs = 0;
  bus_op_t     bus_log[$];
  logic [31:0] bus_mem[logic [29:0]];
  logic [31:0] done_q[$];

  // Background contents of memory words never written.
  function automatic logic [31:0] init_word(input logic [29:0] a);
    return (a == 30'h401) ? 32'hDEAD_BEEF : ({a, 2'b00} ^ 32'hA5A5_5A5A);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] bus_rd(input logic [29:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction

  // External memory: completes a transfer on each acknowledged edge.
  always @(posedge CLK) begin
    if (!RST && ext_req && ext_ack) begin
      bus_op_t op;
      op.we = ext_we;
      op.a  = ext_addr;
      op.d  = ext_wdata;
      op.m  = ext_wmask;
      bus_log.push_back(op);
      if (ext_we) bus_mem[ext_addr] = merge(bus_rd(ext_addr), ext_wdata, ext_wmask);
      hs_count++;
    end
  end

  always @(negedge CLK) begin
    if (hs_count != last_hs) begin
      last_hs = hs_count;
      wcnt = 0;
    end
    if (RST) wcnt = 0;
    if (ext_req && !RST) begin
      if (wcnt >= ack_delay) ext_ack = 1'b1;
      else begin
        ext_ack = 1'b0;
        wcnt++;
      end
    end else begin
      ext_ack = ack_force;
    end
    if (ext_req && !ext_we) ext_rdata = bus_rd(ext_addr);
    else ext_rdata = $urandom;
    if (mem_done) done_q.push_back(read_data);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    rw_flag = 2'd0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Holds the request until an edge at which the responder was not busy.
  task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, output int n);
    logic was_busy;
    rw_flag = t;
    addr = a;
    write_data = d;
    write_mask = m;
    n = 0;
    do begin
      was_busy = mem_busy;
      tick();
      n++;
    end while (was_busy && n < 100);
    rw_flag = 2'd0;
    if (was_busy) begin
      chk++;
      err++;
      $display("FAIL issue_timeout: mem_busy=%0b after %0d cycles, required 0", was_busy, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    chk++;
    if ({mem_busy, mem_done, ext_req, ext_we} !== 4'b0000) begin
      err++;
      $display("FAIL reset_flags: busy/done/req/we=%b required 0000",
               {mem_busy, mem_done, ext_req, ext_we});
    end
    chk++;
    if (read_data !== 32'd0) begin
      err++;
      $display("FAIL reset_read_data: got %h required 0", read_data);
    end
    chk++;
    if ({ext_addr, ext_wdata, ext_wmask} !== 66'd0) begin
      err++;
      $display("FAIL reset_ext_bus: addr=%h wdata=%h wmask=%h required 0", ext_addr, ext_wdata,
               ext_wmask);
    end
    ack_force = 1'b1;
    repeat (3) tick();
    ack_force = 1'b0;
    chk++;
    if (mem_done !== 1'b0 || mem_busy !== 1'b0) begin
      err++;
      $display("FAIL stray_ack: done=%b busy=%b required 0 0", mem_done, mem_busy);
    end
    tick();
  endtask

  task automatic test_read();
    int n;
    do_reset();
    ack_delay = 0;
    issue(2'd1, 32'h0000_1007, 32'h1234_5678, 4'hF, n);
    chk++;
    if (ext_req !== 1'b1 || ext_we !== 1'b0 || mem_busy !== 1'b1) begin
      err++;
      $display("FAIL read_issue: req=%b we=%b busy=%b required 1 0 1", ext_req, ext_we, mem_busy);
    end
    chk++;
    if (ext_addr !== 30'h401) begin
      err++;
      $display("FAIL read_addr: got %h required 00000401", ext_addr);
    end
    tick();
    chk++;
    if (mem_done !== 1'b1 || read_data !== 32'hDEAD_BEEF) begin
      err++;
      $display("FAIL read_done: done=%b data=%h required 1 deadbeef", mem_done, read_data);
    end
    chk++;
    if (mem_busy !== 1'b0 || ext_req !== 1'b0) begin
      err++;
      $display("FAIL read_done_idle: busy=%b req=%b required 0 0", mem_busy, ext_req);
    end
    tick();
    chk++;
    if (mem_done !== 1'b0 || read_data !== 32'd0) begin
      err++;
      $display("FAIL read_after: done=%b data=%h required 0 0", mem_done, read_data);
    end
  endtask

  task automatic test_reset_mid_bus();
    int n;
    int nd0;
    do_reset();
    ack_delay = 6;
    nd0 = done_q.size();
    issue(2'd1, 32'h0000_0C00, 32'd0, 4'd0, n);
    chk++;
    if (ext_req !== 1'b1) begin
      err++;
      $display("FAIL midrst_pre: req=%b required 1", ext_req);
    end
    RST = 1'b1;
    tick();
    chk++;
    if ({ext_req, ext_we, mem_busy, mem_done} !== 4'b0000 || {ext_addr, ext_wdata, ext_wmask} !== 66'd0
        || read_data !== 32'd0) begin
      err++;
      $display("FAIL midrst_outputs: req=%b we=%b busy=%b done=%b addr=%h rd=%h required all 0",
               ext_req, ext_we, mem_busy, mem_done, ext_addr, read_data);
    end
    RST = 1'b0;
    ack_delay = 0;
    repeat (4) tick();
    chk++;
    if (done_q.size() != nd0 || mem_busy !== 1'b0) begin
      err++;
      $display("FAIL midrst_no_done: dones=%0d busy=%b required 0 0", done_q.size() - nd0, mem_busy);
    end
  endtask

`ifndef DMEM_WRITE_BUFFER_EN
  task automatic test_write_delay();
    int n;
    int nd0;
    do_reset();
    ack_delay = 2;
    nd0 = done_q.size();
    issue(2'd2, 32'h0000_0080, 32'h00AB_CD00, 4'b0110, n);
    for (int i = 0; i < 3; i++) begin
      chk++;
      if (mem_busy !== 1'b1 || mem_done !== 1'b0) begin
        err++;
        $display("FAIL wr_busy[%0d]: busy=%b done=%b required 1 0", i, mem_busy, mem_done);
      end
      chk++;
      if ({ext_req, ext_we, ext_addr, ext_wdata, ext_wmask} !==
          {1'b1, 1'b1, 30'h20, 32'h00AB_CD00, 4'b0110}) begin
        err++;
        $display("FAIL wr_ext_stable[%0d]: req=%b we=%b addr=%h wdata=%h wmask=%b", i, ext_req,
                 ext_we, ext_addr, ext_wdata, ext_wmask);
      end
      tick();
    end
    chk++;
    if (mem_done !== 1'b1 || read_data !== 32'd0 || mem_busy !== 1'b0) begin
      err++;
      $display("FAIL wr_done: done=%b data=%h busy=%b required 1 0 0", mem_done, read_data, mem_busy);
    end
    tick();
    tick();
    chk++;
    if (done_q.size() != nd0 + 1) begin
      err++;
      $display("FAIL wr_done_count: got %0d required 1", done_q.size() - nd0);
    end
    chk++;
    if (bus_rd(30'h20) !== merge(init_word(30'h20), 32'h00AB_CD00, 4'b0110)) begin
      err++;
      $display("FAIL wr_mem: got %h required %h", bus_rd(30'h20),
               merge(init_word(30'h20), 32'h00AB_CD00, 4'b0110));
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int nd0;
    do_reset();
    ack_delay = 0;
    nd0 = done_q.size();
    issue(2'd2, 32'h0000_0084, 32'h1122_3344, 4'hF, n);
    issue(2'd1, 32'h0000_0084, 32'd0, 4'd0, n);
    chk++;
    if (n != 2) begin
      err++;
      $display("FAIL b2b_accept_cycles: got %0d required 2", n);
    end
    chk++;
    if (ext_req !== 1'b1 || ext_we !== 1'b0 || ext_addr !== 30'h21) begin
      err++;
      $display("FAIL b2b_req: req=%b we=%b addr=%h required 1 0 00000021", ext_req, ext_we, ext_addr);
    end
    tick();
    chk++;
    if (mem_done !== 1'b1 || read_data !== 32'h1122_3344) begin
      err++;
      $display("FAIL b2b_read: done=%b data=%h required 1 11223344", mem_done, read_data);
    end
    tick();
    chk++;
    if (done_q.size() != nd0 + 2 || done_q[nd0] !== 32'd0 || done_q[nd0+1] !== 32'h1122_3344) begin
      err++;
      $display("FAIL b2b_order: count=%0d required 2 (write 0 then read 11223344)",
               done_q.size() - nd0);
    end
  endtask
`endif

`ifdef DMEM_WRITE_BUFFER_EN
  task automatic test_wbuf_write_read();
    int n;
    int nl0;
    do_reset();
    ack_delay = 0;
    nl0 = bus_log.size();
    issue(2'd2, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, n);
    chk++;
    if (mem_done !== 1'b1 || ext_req !== 1'b0) begin
      err++;
      $display("FAIL wb_posted: done=%b req=%b required 1 0", mem_done, ext_req);
    end
    issue(2'd1, 32'h0000_0040, 32'd0, 4'd0, n);
    chk++;
    if ({ext_req, ext_we, mem_busy} !== 3'b111 || ext_addr !== 30'h10 || ext_wdata !== 32'hCAFE_F00D) begin
      err++;
      $display("FAIL wb_drain: req=%b we=%b busy=%b addr=%h wdata=%h", ext_req, ext_we, mem_busy,
               ext_addr, ext_wdata);
    end
    tick();
    chk++;
    if (ext_req !== 1'b1 || ext_we !== 1'b0 || ext_addr !== 30'h10) begin
      err++;
      $display("FAIL wb_read_issue: req=%b we=%b addr=%h required 1 0 00000010", ext_req, ext_we,
               ext_addr);
    end
    tick();
    chk++;
    if (mem_done !== 1'b1 || read_data !== 32'hCAFE_F00D) begin
      err++;
      $display("FAIL wb_read_done: done=%b data=%h required 1 cafef00d", mem_done, read_data);
    end
    chk++;
    if (bus_log.size() != nl0 + 2 || bus_log[nl0].we !== 1'b1 || bus_log[nl0+1].we !== 1'b0) begin
      err++;
      $display("FAIL wb_bus_order: ops=%0d required write then read", bus_log.size() - nl0);
    end
  endtask

  task automatic test_wbuf_autodrain();
    int n;
    int nd0;
    int c;
    do_reset();
    ack_delay = 1;
    nd0 = done_q.size();
    issue(2'd2, 32'h0000_0044, 32'h5566_7788, 4'b1001, n);
    tick();
    chk++;
    if ({mem_busy, ext_req, ext_we} !== 3'b111 || ext_addr !== 30'h11 || ext_wmask !== 4'b1001) begin
      err++;
      $display("FAIL wb_auto_drain: busy=%b req=%b we=%b addr=%h wmask=%b", mem_busy, ext_req,
               ext_we, ext_addr, ext_wmask);
    end
    c = 0;
    while (mem_busy && c < 20) begin
      tick();
      c++;
    end
    chk++;
    if (mem_busy !== 1'b0 || ext_req !== 1'b0) begin
      err++;
      $display("FAIL wb_auto_idle: busy=%b req=%b required 0 0", mem_busy, ext_req);
    end
    tick();
    tick();
    chk++;
    if (done_q.size() != nd0 + 1) begin
      err++;
      $display("FAIL wb_auto_dones: got %0d required 1", done_q.size() - nd0);
    end
    chk++;
    if (bus_rd(30'h11) !== merge(init_word(30'h11), 32'h5566_7788, 4'b1001)) begin
      err++;
      $display("FAIL wb_auto_mem: got %h required %h", bus_rd(30'h11),
               merge(init_word(30'h11), 32'h5566_7788, 4'b1001));
    end
  endtask
`endif

  // Reference: memory updated in acceptance order; each read sees all earlier writes.
  task automatic test_random();
    logic [31:0] ref_mem[8];
    logic [31:0] exp_q[$];
    logic [1:0]  t;
    logic [1:0]  lo;
    logic [31:0] d;
    logic [3:0]  m;
    int          w;
    int          n;
    int          gap;
    int          nd0;
    do_reset();
    for (int i = 0; i < 8; i++) ref_mem[i] = bus_rd(30'h200 + 30'(i));
    nd0 = done_q.size();
    for (int k = 0; k < 150; k++) begin
      t  = ($urandom_range(0, 1) == 1) ? 2'd1 : 2'd2;
      w  = $urandom_range(0, 7);
      lo = 2'($urandom);
      d  = $urandom;
      m  = 4'($urandom_range(0, 15));
      ack_delay = $urandom_range(0, 3);
      issue(t, {30'h200 + 30'(w), lo}, d, m, n);
      if (t == 2'd2) begin
        ref_mem[w] = merge(ref_mem[w], d, m);
        exp_q.push_back(32'd0);
      end else begin
        exp_q.push_back(ref_mem[w]);
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        rw_flag = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0;
        tick();
      end
      rw_flag = 2'd0;
    end
    for (int c = 0; c < 200 && done_q.size() < nd0 + exp_q.size(); c++) tick();
    repeat (20) tick();
    chk++;
    if (done_q.size() != nd0 + exp_q.size()) begin
      err++;
      $display("FAIL rand_done_count: got %0d required %0d", done_q.size() - nd0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && nd0 + i < done_q.size(); i++) begin
      chk++;
      if (done_q[nd0+i] !== exp_q[i]) begin
        err++;
        $display("FAIL rand_resp[%0d]: got %h required %h", i, done_q[nd0+i], exp_q[i]);
      end
    end
    chk++;
    if (mem_busy !== 1'b0 || ext_req !== 1'b0) begin
      err++;
      $display("FAIL rand_final_idle: busy=%b req=%b required 0 0", mem_busy, ext_req);
    end
    for (int i = 0; i < 8; i++) begin
      chk++;
      if (bus_rd(30'h200 + 30'(i)) !== ref_mem[i]) begin
        err++;
        $display("FAIL rand_mem[%0d]: got %h required %h", i, bus_rd(30'h200 + 30'(i)), ref_mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
`ifndef DMEM_WRITE_BUFFER_EN
    test_write_delay();
    test_back_to_back();
`else
    test_wbuf_write_read();
    test_wbuf_autodrain();
`endif
    test_reset_mid_bus();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
